npc_ctrl: RTL

Next-PC sequencer for the `pc` register. Each cycle it computes `newpc` from the current `oldpc` and the decode, branch, exception and stall controls, and feeds it back to `pc`. It owns the branch-delay-slot state machine and the exception entry/return bookkeeping (EPC, BD, EXL). The datapath instantiates it between `pc` and the control unit.

---
 rtl/npc_pkg.sv | 19 +
 rtl/npc_target.sv | 41 ++++
 rtl/npc_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared types and defaults for the next-PC sequencer.
package npc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    SLOT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CTI_NONE = 2'd0,
    CTI_BR   = 2'd1,
    CTI_J    = 2'd2,
    CTI_JR   = 2'd3
  } cti_sel_t;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/npc_target.sv
// Combinational control-transfer target and priority select (jr > jump > branch).
module npc_target
  import npc_pkg::*;
(
  input  logic [31:0] pc_in,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc4,
  output logic [31:0] target,
  output cti_sel_t    sel
);

  logic signed [31:0] br_disp;
  logic        [31:0] br_tgt;
  logic        [31:0] j_tgt;

  assign pc4     = pc_in + 32'd4;
  assign br_disp = {{14{br_offset[15]}}, br_offset, 2'b00};
  assign br_tgt  = pc4 + $unsigned(br_disp);
  assign j_tgt   = {pc4[31:28], jump_index, 2'b00};

  always_comb begin
    sel    = CTI_NONE;
    target = pc4;
    if (jr) begin
      sel    = CTI_JR;
      target = jr_target;
    end else if (jump) begin
      sel    = CTI_J;
      target = j_tgt;
    end else if (br_taken) begin
      sel    = CTI_BR;
      target = br_tgt;
    end
  end

endmodule

// File: rtl/npc_ctrl.sv
// Next-PC sequencer: delay-slot FSM, exception entry/return (EPC/BD/EXL) and newpc mux.
module npc_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] newpc,
  output logic [31:0] epc,
  output logic        bd,
  output logic        exl,
  output logic        slot_pending
);

  state_t      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic        exl_q, exl_d;

  logic [31:0] pc4;
  logic [31:0] target;
  cti_sel_t    sel;

  npc_target u_target (
    .pc_in      (pc_in),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jump       (jump),
    .jump_index (jump_index),
    .jr         (jr),
    .jr_target  (jr_target),
    .pc4        (pc4),
    .target     (target),
    .sel        (sel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      tgt_q   <= '0;
      epc_q   <= '0;
      bd_q    <= 1'b0;
      exl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      epc_q   <= epc_d;
      bd_q    <= bd_d;
      exl_q   <= exl_d;
    end
  end

  always_comb begin
    newpc   = pc4;
    state_d = state_q;
    tgt_d   = tgt_q;
    epc_d   = epc_q;
    bd_d    = bd_q;
    exl_d   = exl_q;
    if (!reset) begin
      newpc = RESET_PC;
    end else if (exc_req && !exl_q) begin
      // In a delay slot the faulting context is the branch one word back.
      newpc   = EXC_VECTOR;
      exl_d   = 1'b1;
      state_d = RUN;
      epc_d   = (state_q == SLOT) ? (pc_in - 32'd4) : pc_in;
      bd_d    = (state_q == SLOT);
    end else if (stall) begin
      newpc = pc_in;
    end else if (eret && exl_q) begin
      newpc   = epc_q;
      exl_d   = 1'b0;
      bd_d    = 1'b0;
      state_d = RUN;
    end else if (state_q == SLOT) begin
      newpc   = tgt_q;
      state_d = RUN;
    end else if (sel != CTI_NONE) begin
      if (DELAY_SLOT != 0) begin
        tgt_d   = target;
        state_d = SLOT;
      end else begin
        newpc = target;
      end
    end
  end

  assign epc          = epc_q;
  assign bd           = bd_q;
  assign exl          = exl_q;
  assign slot_pending = (state_q == SLOT);

endmodule
